// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word and RAM-state types, plus the arbiter FSM state
// and the request record latched at grant time.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE,
        IGNT,
        DGNT,
        IRESP,
        DRESP
    } arb_state_t;

    typedef struct packed {
        word_t addr;
        word_t store;
        logic  wr;
    } arb_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the datapath, the arbiter and the single-ported RAM.
// slave: the arbiter's view; master: the datapath/RAM environment's view.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      ihit;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dhit;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      mem_timeout;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_timeout
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_timeout
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over increment).
module sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] LIMIT = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && count != LIMIT)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// I/D arbiter onto a single-ported RAM: data wins ties, bounded instruction starvation,
// sticky grant watchdog. Define MEM_ARB_PERF_EN to add icount/dcount/stallcount outputs.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
`ifdef MEM_ARB_PERF_EN
    ,
    output word_t         icount,
    output word_t         dcount,
    output word_t         stallcount
`endif
);

    localparam int ST_W = $clog2(STARVE_LIMIT + 1);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t      state;
    arb_req_t        req;
    logic            ram_ren, ram_wen, mem_timeout;
    word_t           iload, dload;
    logic [ST_W-1:0] starve_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic            d_pend, starved, d_grant, i_grant, in_gnt, wd_trip, ihit, dhit;

    assign d_pend  = bus.dREN | bus.dWEN;
    assign starved = starve_cnt == ST_W'(STARVE_LIMIT);
    // a starved fetch only overrides data when it is actually being requested
    assign d_grant = (state == IDLE) && d_pend && !(starved && bus.iREN);
    assign i_grant = (state == IDLE) && bus.iREN && !d_grant;
    assign in_gnt  = (state == IGNT) || (state == DGNT);
    assign wd_trip = in_gnt && (wd_cnt >= WD_W'(TIMEOUT_CYCLES - 1));

    // hits are withheld when the requester has moved on since the grant
    assign ihit = (state == IRESP) && bus.iREN && (bus.iaddr == req.addr);
    assign dhit = (state == DRESP) && (req.wr ? bus.dWEN : bus.dREN) && (bus.daddr == req.addr);

    sat_counter #(.WIDTH(ST_W), .LIMIT(ST_W'(STARVE_LIMIT))) u_starve (
        .clk(CLK), .rst_n(nRST), .inc(d_grant && bus.iREN), .clr(i_grant), .count(starve_cnt)
    );

    sat_counter #(.WIDTH(WD_W), .LIMIT(WD_W'(TIMEOUT_CYCLES))) u_wd (
        .clk(CLK), .rst_n(nRST), .inc(in_gnt), .clr(!in_gnt), .count(wd_cnt)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            req         <= '0;
            ram_ren     <= 1'b0;
            ram_wen     <= 1'b0;
            iload       <= '0;
            dload       <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (wd_trip)
                mem_timeout <= 1'b1;
            case (state)
                IDLE: begin
                    if (d_grant) begin
                        state   <= DGNT;
                        req     <= '{addr: bus.daddr, store: bus.dstore, wr: bus.dWEN};
                        ram_wen <= bus.dWEN;
                        ram_ren <= !bus.dWEN;
                    end else if (i_grant) begin
                        state    <= IGNT;
                        req.addr <= bus.iaddr;
                        req.wr   <= 1'b0;
                        ram_ren  <= 1'b1;
                    end
                end
                IGNT: begin
                    if (bus.ramstate == ACCESS) begin
                        iload   <= bus.ramload;
                        ram_ren <= 1'b0;
                        state   <= IRESP;
                    end
                end
                DGNT: begin
                    if (bus.ramstate == ACCESS) begin
                        if (!req.wr)
                            dload <= bus.ramload;
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        state   <= DRESP;
                    end
                end
                IRESP, DRESP: state <= IDLE;
                default:      state <= IDLE;
            endcase
        end
    end

    assign bus.ihit        = ihit;
    assign bus.dhit        = dhit;
    assign bus.iload       = iload;
    assign bus.dload       = dload;
    assign bus.ramREN      = ram_ren;
    assign bus.ramWEN      = ram_wen;
    assign bus.ramaddr     = req.addr;
    assign bus.ramstore    = req.store;
    assign bus.mem_timeout = mem_timeout;

`ifdef MEM_ARB_PERF_EN
    sat_counter #(.WIDTH(32)) u_icnt (
        .clk(CLK), .rst_n(nRST), .inc(ihit), .clr(1'b0), .count(icount)
    );
    sat_counter #(.WIDTH(32)) u_dcnt (
        .clk(CLK), .rst_n(nRST), .inc(dhit), .clr(1'b0), .count(dcount)
    );
    sat_counter #(.WIDTH(32)) u_stall (
        .clk(CLK), .rst_n(nRST), .inc(in_gnt), .clr(1'b0), .count(stallcount)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run scored against a memory-array reference model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int STARVE = 4;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    mem_arbiter_if bus ();

`ifdef MEM_ARB_PERF_EN
    word_t icount, dcount, stallcount;
`endif

    mem_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT_CYCLES(8)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .bus(bus)
`ifdef MEM_ARB_PERF_EN
        ,
        .icount(icount),
        .dcount(dcount),
        .stallcount(stallcount)
`endif
    );

    int checks = 0;
    int errors = 0;

    word_t ram_mem [1024];
    word_t ref_mem [1024];

    bit prev_strobe, stuck, rand_mode, err_mode;
    int busy_n, wait_left;

    typedef struct {
        bit    iren, dren, dwen, err;
        word_t iaddr, daddr, dstore, idata, ddata;
        int    busy;
        int    exp_icyc, exp_dcyc, exp_rd, exp_wr;
        word_t exp_dload;
    } vec_t;

    vec_t vecs[7];

    function automatic int idx(input word_t a);
        return int'(a[11:2]);
    endfunction

    function automatic word_t rand_addr();
        return word_t'($urandom_range(0, 15)) << 2;
    endfunction

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // RAM emulation: called once per cycle just after the rising edge
    task automatic ram_drive();
        logic strobe;
        strobe = bus.ramREN | bus.ramWEN;
        if (!strobe) begin
            bus.ramstate = FREE;
        end else begin
            if (!prev_strobe) begin
                wait_left = rand_mode ? int'($urandom_range(0, 3)) : busy_n;
                if (rand_mode) err_mode = 1'($urandom_range(0, 1));
            end
            if (stuck || wait_left > 0) begin
                bus.ramstate = err_mode ? ERROR : BUSY;
                if (wait_left > 0) wait_left--;
            end else begin
                bus.ramstate = ACCESS;
                if (bus.ramWEN) ram_mem[idx(bus.ramaddr)] = bus.ramstore;
                else            bus.ramload = ram_mem[idx(bus.ramaddr)];
            end
        end
        prev_strobe = strobe;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = FREE;
        prev_strobe = 1'b0; stuck = 1'b0; rand_mode = 1'b0; err_mode = 1'b0; busy_n = 0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int ih_cyc, dh_cyc, rd_n, wr_n, bad;
        word_t ih_data, dh_data;
        ih_cyc = -1; dh_cyc = -1; rd_n = 0; wr_n = 0; bad = 0;
        ih_data = 32'hBAD0_BAD0; dh_data = 32'hBAD0_BAD0;
        do_reset();
        if (v.iren) ram_mem[idx(v.iaddr)] = v.idata;
        if (v.dren && !v.dwen) ram_mem[idx(v.daddr)] = v.ddata;
        busy_n = v.busy; err_mode = v.err;
        bus.iaddr = v.iaddr; bus.daddr = v.daddr; bus.dstore = v.dstore;
        for (int c = 0; c < 12; c++) begin
            ram_drive();
            bus.iREN = v.iren && ih_cyc < 0;
            bus.dREN = v.dren && dh_cyc < 0;
            bus.dWEN = v.dwen && dh_cyc < 0;
            @(negedge CLK);
            if (bus.ihit && ih_cyc < 0) begin ih_cyc = c; ih_data = bus.iload; end
            if (bus.dhit && dh_cyc < 0) begin dh_cyc = c; dh_data = bus.dload; end
            if (bus.ramREN) rd_n++;
            if (bus.ramWEN) begin
                wr_n++;
                if (bus.ramaddr !== v.daddr || bus.ramstore !== v.dstore) bad++;
            end
            if (bus.ramREN && (bus.ramWEN || (bus.ramaddr !== v.iaddr && bus.ramaddr !== v.daddr))) bad++;
            @(posedge CLK); #1;
        end
        chk($sformatf("v%0d_ihit_cycle", k), ih_cyc, v.exp_icyc);
        chk($sformatf("v%0d_dhit_cycle", k), dh_cyc, v.exp_dcyc);
        chk($sformatf("v%0d_read_strobes", k), rd_n, v.exp_rd);
        chk($sformatf("v%0d_write_strobes", k), wr_n, v.exp_wr);
        chk($sformatf("v%0d_ram_bus_stable", k), bad, 0);
        if (v.exp_icyc >= 0) chk($sformatf("v%0d_iload", k), ih_data, v.idata);
        if (v.exp_dcyc >= 0) chk($sformatf("v%0d_dload", k), dh_data, v.exp_dload);
        if (v.dwen) chk($sformatf("v%0d_ram_written", k), ram_mem[idx(v.daddr)], v.dstore);
    endtask

    initial begin
        int ih_cyc, dh_cyc, nd, rd_n;
        word_t ih_data, dh_data;
        bit i_pend, d_pend, d_wr;
        int i_age, d_age, d_while_i, max_dwi, spurious, late, both, n_ih, n_dh, n_stall;

        //         iren  dren  dwen  err   iaddr         daddr         dstore        idata         ddata         busy ic  dc  rd wr dload
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0,        32'h0,        32'h2001_0005, 32'h0,        0,   2, -1, 1, 0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0000_0100, 32'h0,        32'h1111_1111, 32'h2222_2222, 0,   5,  2, 2, 0, 32'h2222_2222};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_0200, 32'hDEAD_BEEF, 32'h0,        32'h0,        2,  -1,  4, 0, 3, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_0300, 32'h0,        32'h0,        32'h3333_0003, 1,  -1,  3, 2, 0, 32'h3333_0003};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0048, 32'h0,        32'h0,        32'h4444_0004, 32'h0,        1,   3, -1, 2, 0, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_0180, 32'h1234_5678, 32'h0,        32'h0,        0,  -1,  2, 0, 1, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_004C, 32'h0000_01C0, 32'hCAFE_F00D, 32'h5555_0005, 32'h0,        0,   5,  2, 1, 1, 32'h0};

        for (int i = 0; i < 1024; i++) begin
            ram_mem[i] = (word_t'(i) * 32'h0001_0003) ^ 32'h5A00_0000;
            ref_mem[i] = ram_mem[i];
        end

        do_reset();
        chk("reset_flags", {28'h0, bus.ihit, bus.dhit, bus.ramREN | bus.ramWEN, bus.mem_timeout}, 32'h0);
        chk("reset_ramaddr", bus.ramaddr, 32'h0);
        chk("reset_ramstore", bus.ramstore, 32'h0);
        chk("reset_iload", bus.iload, 32'h0);
        chk("reset_dload", bus.dload, 32'h0);

        for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

        // Starvation: both requests held, zero-wait RAM
        do_reset();
        bus.iaddr = 32'h50; bus.daddr = 32'h140;
        ih_cyc = -1; nd = 0; ih_data = '0;
        for (int c = 0; c < 20; c++) begin
            ram_drive();
            bus.iREN = 1'b1; bus.dREN = 1'b1;
            @(negedge CLK);
            if (bus.dhit && ih_cyc < 0) nd++;
            if (bus.ihit && ih_cyc < 0) begin ih_cyc = c; ih_data = bus.iload; end
            @(posedge CLK); #1;
        end
        chk("starve_dhits_before_ihit", nd, STARVE);
        chk("starve_ihit_cycle", ih_cyc, 14);
        chk("starve_iload", ih_data, ram_mem[idx(32'h50)]);

        // Fetch withdrawn during IGNT, then a fresh fetch
        do_reset();
        busy_n = 1; bus.iaddr = 32'h54;
        ih_cyc = -1; rd_n = 0; ih_data = '0;
        for (int c = 0; c < 12; c++) begin
            ram_drive();
            bus.iREN = (c == 0) || (c >= 5 && ih_cyc < 0);
            @(negedge CLK);
            if (bus.ihit && ih_cyc < 0) begin ih_cyc = c; ih_data = bus.iload; end
            if (bus.ramREN) rd_n++;
            @(posedge CLK); #1;
        end
        chk("withdraw_ihit_cycle", ih_cyc, 8);
        chk("withdraw_read_strobes", rd_n, 4);
        chk("withdraw_iload", ih_data, ram_mem[idx(32'h54)]);

        // Data address changes after grant: first hit suppressed
        do_reset();
        bus.daddr = 32'h160;
        dh_cyc = -1; dh_data = '0;
        for (int c = 0; c < 10; c++) begin
            ram_drive();
            bus.dREN = dh_cyc < 0;
            if (c == 1) bus.daddr = 32'h164;
            @(negedge CLK);
            if (bus.dhit && dh_cyc < 0) begin dh_cyc = c; dh_data = bus.dload; end
            @(posedge CLK); #1;
        end
        chk("addr_change_dhit_cycle", dh_cyc, 5);
        chk("addr_change_dload", dh_data, ram_mem[idx(32'h164)]);

        // Watchdog with RAM stuck BUSY, then reset mid-grant
        do_reset();
        stuck = 1'b1; bus.iaddr = 32'h58; ih_cyc = -1;
        for (int c = 0; c < 11; c++) begin
            ram_drive();
            bus.iREN = 1'b1;
            @(negedge CLK);
            if (bus.ihit) ih_cyc = c;
            if (c == 8) chk("timeout_not_yet", bus.mem_timeout, 1'b0);
            if (c == 9) chk("timeout_set", bus.mem_timeout, 1'b1);
            if (c == 10) chk("stuck_still_granted", bus.ramREN, 1'b1);
            if (c < 10) begin @(posedge CLK); #1; end
        end
        chk("stuck_no_ihit", ih_cyc, -1);
        #1 nRST = 1'b0;
        #1;
        chk("reset_drops_ramREN", bus.ramREN, 1'b0);
        chk("reset_clears_timeout", bus.mem_timeout, 1'b0);

        // Randomized traffic scored against the memory-array reference
        for (int i = 0; i < 1024; i++) ref_mem[i] = ram_mem[i];
        do_reset();
        rand_mode = 1'b1;
        i_pend = 0; d_pend = 0; d_wr = 0; i_age = 0; d_age = 0;
        d_while_i = 0; max_dwi = 0; spurious = 0; late = 0; both = 0;
        n_ih = 0; n_dh = 0; n_stall = 0;
        for (int n = 0; n < 3000; n++) begin
            ram_drive();
            if (!i_pend && $urandom_range(0, 2) != 0) begin
                i_pend = 1; i_age = 0; bus.iaddr = rand_addr();
            end
            bus.iREN = i_pend;
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend = 1; d_age = 0; d_wr = 1'($urandom_range(0, 1));
                bus.daddr = rand_addr(); bus.dstore = $urandom;
            end
            bus.dREN = d_pend && !d_wr;
            bus.dWEN = d_pend && d_wr;
            @(negedge CLK);
            if (bus.ramREN | bus.ramWEN) n_stall++;
            if (bus.ihit && bus.dhit) both++;
            if (bus.ihit) begin
                if (!i_pend) spurious++;
                else begin
                    chk("rand_iload", bus.iload, ref_mem[idx(bus.iaddr)]);
                    i_pend = 0; n_ih++; d_while_i = 0;
                end
            end
            if (bus.dhit) begin
                if (!d_pend) spurious++;
                else begin
                    if (d_wr) ref_mem[idx(bus.daddr)] = bus.dstore;
                    else chk("rand_dload", bus.dload, ref_mem[idx(bus.daddr)]);
                    d_pend = 0; n_dh++;
                    if (i_pend) d_while_i++;
                    if (d_while_i > max_dwi) max_dwi = d_while_i;
                end
            end
            if (i_pend && ++i_age > 80) begin late++; i_pend = 0; end
            if (d_pend && ++d_age > 80) begin late++; d_pend = 0; end
            @(posedge CLK); #1;
        end
        chk("rand_no_spurious_hits", spurious, 0);
        chk("rand_no_late_requests", late, 0);
        chk("rand_hits_exclusive", both, 0);
        chk("rand_starvation_bound", max_dwi <= STARVE + 1, 1'b1);
        chk("rand_progress", (n_ih > 0) && (n_dh > 0), 1'b1);
        chk("rand_no_timeout", bus.mem_timeout, 1'b0);
`ifdef MEM_ARB_PERF_EN
        chk("perf_icount", icount, n_ih);
        chk("perf_dcount", dcount, n_dh);
        chk("perf_stallcount", stallcount, n_stall);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
